// File: rtl/aib_sr_ms_link_fsm_if.sv
// Handshake/status bundle between the master bring-up sequencer and its environment
// (shift-register master, slave capture flags, local DCC/DLL status).
interface aib_sr_ms_link_fsm_if;
  logic       start_cal;
  logic       tx_dcc_cal_done;
  logic       rx_dll_lock;
  logic       sl_osc_transfer_en;
  logic       sl_tx_transfer_en;
  logic       sl_rx_transfer_en;
  logic       ms_osc_transfer_en;
  logic       ms_tx_dcc_cal_start;
  logic       ms_tx_transfer_en;
  logic       ms_rx_dll_start;
  logic       ms_rx_transfer_en;
  logic       link_up;
  logic       cal_err;
  logic [2:0] fsm_state;

  // Sequencer side.
  modport master (
    input  start_cal, tx_dcc_cal_done, rx_dll_lock,
    input  sl_osc_transfer_en, sl_tx_transfer_en, sl_rx_transfer_en,
    output ms_osc_transfer_en, ms_tx_dcc_cal_start, ms_tx_transfer_en,
    output ms_rx_dll_start, ms_rx_transfer_en, link_up, cal_err, fsm_state
  );

  // Environment side.
  modport slave (
    output start_cal, tx_dcc_cal_done, rx_dll_lock,
    output sl_osc_transfer_en, sl_tx_transfer_en, sl_rx_transfer_en,
    input  ms_osc_transfer_en, ms_tx_dcc_cal_start, ms_tx_transfer_en,
    input  ms_rx_dll_start, ms_rx_transfer_en, link_up, cal_err, fsm_state
  );
endinterface

// File: rtl/aib_sr_ms_link_fsm.sv
// Master-side sideband link bring-up sequencer: OSC -> TX -> RX handshakes to link-up,
// with deglitched slave flags, a per-stage timeout and an error state.
module aib_sr_ms_link_fsm #(
  parameter int unsigned             STABLE_CNT = 8,
  parameter int unsigned             TIMEOUT_W  = 16,
  parameter logic [TIMEOUT_W-1:0]    TIMEOUT    = 16'd50000
) (
  input  logic                       osc_clk,
  input  logic                       osc_fsm_ms_rstn,
  aib_sr_ms_link_fsm_if.master       bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StOsc    = 3'd1,
    StTxDcc  = 3'd2,
    StTxXfer = 3'd3,
    StRxDll  = 3'd4,
    StRxXfer = 3'd5,
    StLinkUp = 3'd6,
    StError  = 3'd7
  } state_e;

  localparam logic [7:0]           StableMax   = 8'(STABLE_CNT);
  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT - TIMEOUT_W'(1);

  // Slave flag filters: index 0 = osc, 1 = tx, 2 = rx.
  logic [2:0] sl_raw;
  logic [2:0] sync1_q, sync_q;
  logic [7:0] cnt_q [3];
  logic [2:0] flt;

  assign sl_raw = {bus.sl_rx_transfer_en, bus.sl_tx_transfer_en, bus.sl_osc_transfer_en};

  always_ff @(posedge osc_clk) begin
    if (!osc_fsm_ms_rstn) begin
      sync1_q <= '0;
      sync_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sl_raw;
      sync_q  <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (!sync_q[i])                cnt_q[i] <= '0;
        else if (cnt_q[i] != StableMax) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    flt = '0;
    for (int i = 0; i < 3; i++) flt[i] = (cnt_q[i] == StableMax);
  end

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 waiting, exit_ok;
  logic                 osc_en_q, dcc_start_q, tx_en_q, dll_start_q, rx_en_q;
  logic                 link_up_q, cal_err_q;

  always_comb begin
    state_d = state_q;
    waiting = 1'b0;
    exit_ok = 1'b0;
    unique case (state_q)
      StIdle:   if (bus.start_cal) state_d = StOsc;
      StOsc:    begin waiting = 1'b1; exit_ok = flt[0];              end
      StTxDcc:  begin waiting = 1'b1; exit_ok = bus.tx_dcc_cal_done; end
      StTxXfer: begin waiting = 1'b1; exit_ok = flt[1];              end
      StRxDll:  begin waiting = 1'b1; exit_ok = bus.rx_dll_lock;     end
      StRxXfer: begin waiting = 1'b1; exit_ok = flt[2];              end
      StLinkUp: if (!(&flt)) state_d = StError;
      StError:  state_d = StError;
      default:  state_d = StIdle;
    endcase
    // Exit beats the timeout when both land in the same cycle.
    if (waiting) begin
      if (exit_ok)                     state_d = state_e'(state_q + 3'd1);
      else if (timer_q == TimeoutLast) state_d = StError;
    end
    if (!bus.start_cal) state_d = StIdle;
  end

  always_comb begin
    timer_d = '0;
    if (waiting && state_d == state_q) begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + TIMEOUT_W'(1);
    end
  end

  // Outputs decode the next state so they line up with fsm_state.
  always_ff @(posedge osc_clk) begin
    if (!osc_fsm_ms_rstn) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      osc_en_q    <= 1'b0;
      dcc_start_q <= 1'b0;
      tx_en_q     <= 1'b0;
      dll_start_q <= 1'b0;
      rx_en_q     <= 1'b0;
      link_up_q   <= 1'b0;
      cal_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      osc_en_q    <= (state_d >= StOsc)    && (state_d <= StLinkUp);
      dcc_start_q <= (state_d >= StTxDcc)  && (state_d <= StLinkUp);
      tx_en_q     <= (state_d >= StTxXfer) && (state_d <= StLinkUp);
      dll_start_q <= (state_d >= StRxDll)  && (state_d <= StLinkUp);
      rx_en_q     <= (state_d >= StRxXfer) && (state_d <= StLinkUp);
      link_up_q   <= (state_d == StLinkUp);
      cal_err_q   <= (state_d == StError);
    end
  end

  assign bus.ms_osc_transfer_en  = osc_en_q;
  assign bus.ms_tx_dcc_cal_start = dcc_start_q;
  assign bus.ms_tx_transfer_en   = tx_en_q;
  assign bus.ms_rx_dll_start     = dll_start_q;
  assign bus.ms_rx_transfer_en   = rx_en_q;
  assign bus.link_up             = link_up_q;
  assign bus.cal_err             = cal_err_q;
  assign bus.fsm_state           = state_q;

endmodule

// File: tb/tb_aib_sr_ms_link_fsm.sv
// Directed bench for the link bring-up sequencer: nominal, glitch, timeout, race, link loss
// and mid-sequence reset, with STABLE_CNT=8 and TIMEOUT=200.
module tb_aib_sr_ms_link_fsm;

  logic osc_clk;
  logic osc_fsm_ms_rstn;
  int   n_checks;
  int   n_err;

  aib_sr_ms_link_fsm_if bus ();

  aib_sr_ms_link_fsm #(
    .STABLE_CNT (8),
    .TIMEOUT_W  (16),
    .TIMEOUT    (16'd200)
  ) dut (
    .osc_clk         (osc_clk),
    .osc_fsm_ms_rstn (osc_fsm_ms_rstn),
    .bus             (bus.master)
  );

  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  // {osc_en, dcc_start, tx_en, dll_start, rx_en, link_up, cal_err}
  logic [6:0] outs;
  assign outs = {bus.ms_osc_transfer_en, bus.ms_tx_dcc_cal_start, bus.ms_tx_transfer_en,
                 bus.ms_rx_dll_start, bus.ms_rx_transfer_en, bus.link_up, bus.cal_err};

  localparam logic [6:0] OIdle = 7'b0000000;
  localparam logic [6:0] O1    = 7'b1000000;
  localparam logic [6:0] O2    = 7'b1100000;
  localparam logic [6:0] O3    = 7'b1110000;
  localparam logic [6:0] O4    = 7'b1111000;
  localparam logic [6:0] O5    = 7'b1111100;
  localparam logic [6:0] O6    = 7'b1111110;
  localparam logic [6:0] OErr  = 7'b0000001;

  task automatic step(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp_st, input logic [6:0] exp_out);
    n_checks++;
    assert (bus.fsm_state === exp_st) else begin
      n_err++;
      $error("FAIL %s state: got %0d expected %0d", tag, bus.fsm_state, exp_st);
    end
    n_checks++;
    assert (outs === exp_out) else begin
      n_err++;
      $error("FAIL %s outs: got %b expected %b", tag, outs, exp_out);
    end
  endtask

  task automatic set_flag(input int idx, input logic v);
    case (idx)
      0:       bus.sl_osc_transfer_en = v;
      1:       bus.sl_tx_transfer_en  = v;
      default: bus.sl_rx_transfer_en  = v;
    endcase
  endtask

  task automatic set_local(input int idx, input logic v);
    if (idx == 0) bus.tx_dcc_cal_done = v;
    else          bus.rx_dll_lock     = v;
  endtask

  // Slave flag raised 5 cycles after entry: first sampled 5 edges later, advance 10 edges after.
  task automatic xfer_stage(input string tag, input int idx, input logic [2:0] st,
                            input logic [6:0] o_cur, input logic [6:0] o_nxt);
    step(4);
    set_flag(idx, 1'b1);
    step(10);
    chk({tag, "_hold"}, st, o_cur);
    step(1);
    chk({tag, "_adv"}, st + 3'd1, o_nxt);
  endtask

  // Local status raised before edge k advances at edge k.
  task automatic local_stage(input string tag, input int idx, input logic [2:0] st,
                             input logic [6:0] o_cur, input logic [6:0] o_nxt);
    step(4);
    chk({tag, "_hold"}, st, o_cur);
    set_local(idx, 1'b1);
    step(1);
    chk({tag, "_adv"}, st + 3'd1, o_nxt);
  endtask

  task automatic clear_all();
    bus.start_cal          = 1'b0;
    bus.tx_dcc_cal_done    = 1'b0;
    bus.rx_dll_lock        = 1'b0;
    bus.sl_osc_transfer_en = 1'b0;
    bus.sl_tx_transfer_en  = 1'b0;
    bus.sl_rx_transfer_en  = 1'b0;
    step(4);
  endtask

  task automatic start_run(input string tag);
    bus.start_cal = 1'b1;
    step(1);
    chk(tag, 3'd1, O1);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    osc_fsm_ms_rstn = 1'b0;
    bus.start_cal          = 1'b0;
    bus.tx_dcc_cal_done    = 1'b0;
    bus.rx_dll_lock        = 1'b0;
    bus.sl_osc_transfer_en = 1'b0;
    bus.sl_tx_transfer_en  = 1'b0;
    bus.sl_rx_transfer_en  = 1'b0;
    step(2);
    chk("reset", 3'd0, OIdle);
    osc_fsm_ms_rstn = 1'b1;
    step(2);
    chk("idle_no_start", 3'd0, OIdle);

    // Nominal bring-up.
    start_run("n_osc");
    xfer_stage("n_osc", 0, 3'd1, O1, O2);
    local_stage("n_dcc", 0, 3'd2, O2, O3);
    xfer_stage("n_tx", 1, 3'd3, O3, O4);
    local_stage("n_dll", 1, 3'd4, O4, O5);
    xfer_stage("n_rx", 2, 3'd5, O5, O6);

    // Link loss: flag drops, sync takes 2 edges, filter 1, state 1.
    bus.sl_tx_transfer_en = 1'b0;
    step(3);
    chk("loss_hold", 3'd6, O6);
    step(1);
    chk("loss_err", 3'd7, OErr);
    step(5);
    chk("err_sticky", 3'd7, OErr);
    bus.start_cal = 1'b0;
    step(1);
    chk("err_to_idle", 3'd0, OIdle);
    clear_all();

    // Restart with a 7-cycle glitch on the OSC flag, then a full bring-up.
    start_run("g_osc");
    step(2);
    bus.sl_osc_transfer_en = 1'b1;
    step(7);
    bus.sl_osc_transfer_en = 1'b0;
    step(3);
    chk("glitch_mid", 3'd1, O1);
    step(3);
    chk("glitch_after", 3'd1, O1);
    bus.sl_osc_transfer_en = 1'b1;
    step(10);
    chk("glitch_hold", 3'd1, O1);
    step(1);
    chk("glitch_adv", 3'd2, O2);
    local_stage("r_dcc", 0, 3'd2, O2, O3);
    xfer_stage("r_tx", 1, 3'd3, O3, O4);
    local_stage("r_dll", 1, 3'd4, O4, O5);
    xfer_stage("r_rx", 2, 3'd5, O5, O6);
    clear_all();
    chk("clear_idle", 3'd0, OIdle);

    // Timeout in TXDCC: ERROR exactly 200 edges after entry.
    start_run("t_osc");
    xfer_stage("t_osc", 0, 3'd1, O1, O2);
    step(199);
    chk("to_last", 3'd2, O2);
    step(1);
    chk("to_err", 3'd7, OErr);
    step(3);
    chk("to_sticky", 3'd7, OErr);
    bus.start_cal = 1'b0;
    step(1);
    chk("to_idle", 3'd0, OIdle);
    clear_all();

    // Exit and timeout in the same cycle: exit wins.
    start_run("s_osc");
    xfer_stage("s_osc", 0, 3'd1, O1, O2);
    local_stage("s_dcc", 0, 3'd2, O2, O3);
    xfer_stage("s_tx", 1, 3'd3, O3, O4);
    step(199);
    chk("race_pre", 3'd4, O4);
    bus.rx_dll_lock = 1'b1;
    step(1);
    chk("race_exit", 3'd5, O5);

    // One-cycle reset in RXXFER, then restart with every input already high.
    osc_fsm_ms_rstn       = 1'b0;
    bus.sl_rx_transfer_en = 1'b1;
    step(1);
    chk("midrst", 3'd0, OIdle);
    osc_fsm_ms_rstn = 1'b1;
    step(1);
    chk("rst_osc", 3'd1, O1);
    step(9);
    chk("rst_osc_hold", 3'd1, O1);
    step(1);
    chk("rst_dcc", 3'd2, O2);
    step(1);
    chk("rst_tx", 3'd3, O3);
    step(1);
    chk("rst_dll", 3'd4, O4);
    step(1);
    chk("rst_rx", 3'd5, O5);
    step(1);
    chk("rst_linkup", 3'd6, O6);
    step(3);
    chk("rst_linkup_hold", 3'd6, O6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
